mem_stage_ctrl: RTL

MEM-stage controller that consumes the EX/MEM pipeline register outputs and performs the data-memory access on a request/acknowledge data bus. It tolerates multi-cycle memory latency by asserting a pipeline stall, then produces the registered MEM/WB stage outputs. It sits between EX/MEM and the write-back stage, and it feeds the hazard unit through mem_stall.

---
 rtl/mem_stage_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller between EX/MEM and write-back.
// It performs the data-memory access over a req/ack bus and stalls the
// pipeline while the access is outstanding. The MEM/WB outputs are registered.
//   clk, rst                 clock (rising edge), async active-low reset
//   EX_MEM_*                 EX/MEM pipeline register fields
//   bus_req/we/addr/wdata    registered memory request; bus_rdata/bus_ack return
//   mem_stall                combinational stall to the hazard unit
//   MEM_WB_*                 registered MEM/WB stage outputs
//   addr_err, timeout_err    one-cycle error pulses aligned with the MEM/WB capture
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  EX_MEM_RegWrAddr,
  input  logic [31:0] EX_MEM_ALUOut,
  input  logic [31:0] EX_MEM_Rt,
  input  logic        EX_MEM_MemRd,
  input  logic        EX_MEM_MemWr,
  input  logic [1:0]  EX_MEM_MemtoReg,
  input  logic        EX_MEM_RegWr,
  input  logic [31:0] EX_MEM_PC4,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        mem_stall,
  output logic [4:0]  MEM_WB_RegWrAddr,
  output logic [31:0] MEM_WB_ALUOut,
  output logic [31:0] MEM_WB_MemData,
  output logic [1:0]  MEM_WB_MemtoReg,
  output logic        MEM_WB_RegWr,
  output logic [31:0] MEM_WB_PC4,
  output logic        addr_err,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   hold, hold_nx;
  logic          to_flag, to_flag_nx;
  logic          stall;

  logic          bus_req_nx, bus_we_nx;
  logic [31:0]   bus_addr_nx, bus_wdata_nx;
  logic [4:0]    wb_regwraddr_nx;
  logic [31:0]   wb_aluout_nx, wb_memdata_nx, wb_pc4_nx;
  logic [1:0]    wb_memtoreg_nx;
  logic          wb_regwr_nx;
  logic          addr_err_nx, timeout_err_nx;

  logic          mem_op, misaligned;

  assign mem_op     = EX_MEM_MemRd | EX_MEM_MemWr;
  assign misaligned = (EX_MEM_ALUOut[1:0] != 2'b00);

  // Gated by rst so the stall drops the instant reset is asserted, even while
  // EX/MEM still holds a memory op.
  assign mem_stall = rst & stall;

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    hold_nx         = hold;
    to_flag_nx      = to_flag;
    stall           = 1'b0;
    bus_req_nx      = bus_req;
    bus_we_nx       = bus_we;
    bus_addr_nx     = bus_addr;
    bus_wdata_nx    = bus_wdata;
    wb_regwraddr_nx = EX_MEM_RegWrAddr;
    wb_aluout_nx    = EX_MEM_ALUOut;
    wb_memtoreg_nx  = EX_MEM_MemtoReg;
    wb_pc4_nx       = EX_MEM_PC4;
    wb_regwr_nx     = 1'b0;
    wb_memdata_nx   = '0;
    addr_err_nx     = 1'b0;
    timeout_err_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (!mem_op) begin
          wb_regwr_nx = EX_MEM_RegWr;
        end else if (misaligned) begin
          addr_err_nx = 1'b1;
        end else begin
          stall        = 1'b1;
          state_nx     = BUSY;
          cnt_nx       = '0;
          to_flag_nx   = 1'b0;
          bus_req_nx   = 1'b1;
          bus_we_nx    = EX_MEM_MemWr & ~EX_MEM_MemRd;
          bus_addr_nx  = EX_MEM_ALUOut;
          bus_wdata_nx = EX_MEM_Rt;
        end
      end
      BUSY: begin
        stall = 1'b1;
        // Ack has priority over the expiring counter.
        if (bus_ack) begin
          hold_nx    = bus_rdata;
          bus_req_nx = 1'b0;
          state_nx   = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          bus_req_nx = 1'b0;
          to_flag_nx = 1'b1;
          state_nx   = DONE;
        end else if (cnt != '1) begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (to_flag) begin
          timeout_err_nx = 1'b1;
        end else begin
          wb_regwr_nx   = EX_MEM_RegWr;
          wb_memdata_nx = hold;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      hold             <= '0;
      to_flag          <= 1'b0;
      bus_req          <= 1'b0;
      bus_we           <= 1'b0;
      bus_addr         <= '0;
      bus_wdata        <= '0;
      MEM_WB_RegWrAddr <= '0;
      MEM_WB_ALUOut    <= '0;
      MEM_WB_MemData   <= '0;
      MEM_WB_MemtoReg  <= '0;
      MEM_WB_RegWr     <= 1'b0;
      MEM_WB_PC4       <= '0;
      addr_err         <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      hold             <= hold_nx;
      to_flag          <= to_flag_nx;
      bus_req          <= bus_req_nx;
      bus_we           <= bus_we_nx;
      bus_addr         <= bus_addr_nx;
      bus_wdata        <= bus_wdata_nx;
      MEM_WB_RegWrAddr <= wb_regwraddr_nx;
      MEM_WB_ALUOut    <= wb_aluout_nx;
      MEM_WB_MemData   <= wb_memdata_nx;
      MEM_WB_MemtoReg  <= wb_memtoreg_nx;
      MEM_WB_RegWr     <= wb_regwr_nx;
      MEM_WB_PC4       <= wb_pc4_nx;
      addr_err         <= addr_err_nx;
      timeout_err      <= timeout_err_nx;
    end
  end

endmodule
